// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch slice:
//   XLEN             - datapath width (32)
//   RESET_PC_DEFAULT - PC loaded on reset unless the top overrides RESET_PC
//   fetch_state_e    - fetch FSM states
//                      S_FETCH : request outstanding, waiting for imem_ack
//                      S_HOLD  : instruction presented, waiting for dec_ready
//                      S_STOP  : idle, no request and nothing valid
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_3000;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_STOP  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_if.sv
// -----------------------------------------------------------------------------
// fetch_if
// Bundles the instruction-memory bus and the fetch->decode handshake.
//   imem_req / imem_addr : request strobe and address (address equals PC)
//   imem_ack / imem_rdata: acknowledge; rdata is valid in the ack cycle
//   Instr / instr_valid  : instruction offered to decode
//   dec_ready            : decode accepts Instr this cycle
// Handshake rule: an instruction transfers to decode on a cycle where
// instr_valid & dec_ready are both high. While instr_valid is high, Instr
// does not change; dec_ready has no effect while instr_valid is low.
// Modports: master = fetch side, slave = memory/decode side.
// -----------------------------------------------------------------------------
interface fetch_if;
  import fetch_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;
  logic [XLEN-1:0] Instr;
  logic            instr_valid;
  logic            dec_ready;

  modport master (
    output imem_req, imem_addr, Instr, instr_valid,
    input  imem_ack, imem_rdata, dec_ready
  );

  modport slave (
    input  imem_req, imem_addr, Instr, instr_valid,
    output imem_ack, imem_rdata, dec_ready
  );

endinterface

// File: rtl/fetch_fsm.sv
// -----------------------------------------------------------------------------
// fetch_fsm
// Control FSM for the fetch unit: FETCH -> HOLD -> (FETCH | STOP).
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   imem_ack_i      - memory acknowledge (only honoured in S_FETCH)
//   dec_ready_i     - decode ready (only honoured in S_HOLD)
//   halt_i          - stop after the instruction currently being delivered
//   misalign_i      - NPC misaligned at this handshake (0 when not checked)
//   imem_req_o      - request strobe
//   instr_valid_o   - registered valid towards decode
//   take_instr_o    - capture imem_rdata into the instruction register
//   handshake_o     - instruction accepted by decode this cycle
//   align_err_o     - sticky misalignment flag, cleared only by rst
//   state_o         - current state, for debug/observation
// -----------------------------------------------------------------------------
module fetch_fsm
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         imem_ack_i,
  input  logic         dec_ready_i,
  input  logic         halt_i,
  input  logic         misalign_i,
  output logic         imem_req_o,
  output logic         instr_valid_o,
  output logic         take_instr_o,
  output logic         handshake_o,
  output logic         align_err_o,
  output fetch_state_e state_o
);

  fetch_state_e state_q;
  logic         valid_q;
  logic         align_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_FETCH;
      valid_q     <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          // halt is not looked at here: the outstanding request always
          // completes and its instruction is always delivered.
          if (imem_ack_i) begin
            state_q <= S_HOLD;
            valid_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (dec_ready_i) begin
            valid_q <= 1'b0;
            if (misalign_i) begin
              align_err_q <= 1'b1;
              state_q     <= S_STOP;
            end else if (halt_i) begin
              state_q <= S_STOP;
            end else begin
              state_q <= S_FETCH;
            end
          end
        end
        S_STOP: begin
          // A misalignment stop is permanent until reset.
          if (!halt_i && !align_err_q) begin
            state_q <= S_FETCH;
          end
        end
        default: begin
          state_q <= S_FETCH;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Gated by rst so the request drops the moment reset asserts and is
  // present as soon as reset is released.
  assign imem_req_o    = (state_q == S_FETCH) && !rst;
  assign instr_valid_o = valid_q;
  assign take_instr_o  = (state_q == S_FETCH) && imem_ack_i;
  assign handshake_o   = valid_q && dec_ready_i;
  assign align_err_o   = align_err_q;
  assign state_o       = state_q;

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage: holds PC, the fetched instruction and the count of
// delivered instructions; sequencing lives in fetch_fsm.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   bus          - fetch_if.master (imem request/ack, decode handshake)
//   NPC          - next PC from the npc stage, loaded on each handshake
//   halt         - stop fetching after the instruction being delivered
//   PC           - address of the instruction being fetched or held
//   PC_add_4     - PC + 4 (wraps modulo 2^32)
//   align_err    - sticky misaligned-NPC flag
//   fetch_cnt    - delivered instruction count (wraps silently)
//   dbg_state_o  - FSM state for observation
// Configuration:
//   FETCH_ALIGN_CHECK_EN defined   : misaligned NPC at a handshake loads PC
//                                    unchanged, sets align_err, stops for good.
//   FETCH_ALIGN_CHECK_EN undefined : NPC low two bits are forced to zero and
//                                    align_err stays 0.
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  fetch_if.master         bus,
  input  logic [XLEN-1:0] NPC,
  input  logic            halt,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PC_add_4,
  output logic            align_err,
  output logic [XLEN-1:0] fetch_cnt,
  output fetch_state_e    dbg_state_o
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] cnt_q;
  logic [XLEN-1:0] pc_d;
  logic            misalign;
  logic            take_instr;
  logic            handshake;

`ifdef FETCH_ALIGN_CHECK_EN
  assign misalign = |NPC[1:0];
  assign pc_d     = NPC;
`else
  assign misalign = 1'b0;
  assign pc_d     = NPC & {{(XLEN-2){1'b1}}, 2'b00};
`endif

  fetch_fsm u_fsm (
    .clk           (clk),
    .rst           (rst),
    .imem_ack_i    (bus.imem_ack),
    .dec_ready_i   (bus.dec_ready),
    .halt_i        (halt),
    .misalign_i    (misalign),
    .imem_req_o    (bus.imem_req),
    .instr_valid_o (bus.instr_valid),
    .take_instr_o  (take_instr),
    .handshake_o   (handshake),
    .align_err_o   (align_err),
    .state_o       (dbg_state_o)
  );

  // PC and counter only move on a handshake, Instr only on an accepted ack,
  // so all three are stable while a request or valid is pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
      cnt_q   <= '0;
    end else begin
      if (take_instr) begin
        instr_q <= bus.imem_rdata;
      end
      if (handshake) begin
        pc_q  <= pc_d;
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign PC            = pc_q;
  assign PC_add_4      = pc_q + 32'd4;
  assign bus.imem_addr = pc_q;
  assign bus.Instr     = instr_q;
  assign fetch_cnt     = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit. Inputs change on the falling edge, outputs
// are sampled on the falling edge (half a cycle after the active edge).
// Expected values are hand-derived constants.
// -----------------------------------------------------------------------------
module tb_fetch_unit;
  import fetch_pkg::*;

  logic         clk;
  logic         rst;
  logic [31:0]  npc;
  logic         halt;
  logic [31:0]  pc;
  logic [31:0]  pc_add_4;
  logic         align_err;
  logic [31:0]  fetch_cnt;
  fetch_state_e dbg_state;

  int n_checks;
  int n_pass;

  fetch_if bus_if ();

  fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_if.master),
    .NPC         (npc),
    .halt        (halt),
    .PC          (pc),
    .PC_add_4    (pc_add_4),
    .align_err   (align_err),
    .fetch_cnt   (fetch_cnt),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the directed sequence is fixed length, this only guards hangs.
  initial begin
    #20000;
    $display("FAIL watchdog: sim time exceeded, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    bus_if.imem_ack   = 1'b0;
    bus_if.imem_rdata = 32'h0;
    bus_if.dec_ready  = 1'b0;
  endtask

  // Ack the pending request now; valid must appear one cycle later.
  task automatic give_ack(input logic [31:0] data);
    bus_if.imem_ack   = 1'b1;
    bus_if.imem_rdata = data;
    next_cycle();
    bus_if.imem_ack   = 1'b0;
    bus_if.imem_rdata = 32'hDEAD_BEEF;
  endtask

  // Accept the held instruction with the given next PC.
  task automatic accept(input logic [31:0] next_pc);
    bus_if.dec_ready = 1'b1;
    npc              = next_pc;
    next_cycle();
    bus_if.dec_ready = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    halt     = 1'b0;
    npc      = 32'h0;
    drive_idle();

    repeat (3) next_cycle();
    check_eq("rst_pc",        pc,                        32'h0000_3000);
    check_eq("rst_instr",     bus_if.Instr,              32'h0);
    check_eq("rst_valid",     {31'b0, bus_if.instr_valid}, 32'h0);
    check_eq("rst_req",       {31'b0, bus_if.imem_req},  32'h0);
    check_eq("rst_cnt",       fetch_cnt,                 32'h0);
    check_eq("rst_align",     {31'b0, align_err},        32'h0);

    // Reset release: request is up immediately at the reset PC.
    rst = 1'b0;
    #1;
    check_eq("rel_req",       {31'b0, bus_if.imem_req},  32'h1);
    check_eq("rel_addr",      bus_if.imem_addr,          32'h0000_3000);
    check_eq("rel_pc4",       pc_add_4,                  32'h0000_3004);

    // dec_ready while fetching must not move anything.
    bus_if.dec_ready = 1'b1;
    npc              = 32'h0000_5550;
    next_cycle();
    bus_if.dec_ready = 1'b0;
    next_cycle();
    check_eq("fetch_wait_req", {31'b0, bus_if.imem_req}, 32'h1);
    check_eq("fetch_wait_pc",  pc,                       32'h0000_3000);
    check_eq("fetch_wait_val", {31'b0, bus_if.instr_valid}, 32'h0);

    // First instruction.
    give_ack(32'h2008_0005);
    check_eq("i0_valid",      {31'b0, bus_if.instr_valid}, 32'h1);
    check_eq("i0_instr",      bus_if.Instr,              32'h2008_0005);
    check_eq("i0_req",        {31'b0, bus_if.imem_req},  32'h0);
    check_eq("i0_state",      32'(dbg_state),            32'(S_HOLD));

    // Stall for 3 cycles; a stray ack in HOLD must be ignored.
    for (int i = 0; i < 3; i++) begin
      bus_if.imem_ack   = (i == 1);
      bus_if.imem_rdata = 32'h1111_2222;
      next_cycle();
      check_eq("stall_instr", bus_if.Instr,              32'h2008_0005);
      check_eq("stall_pc",    pc,                        32'h0000_3000);
      check_eq("stall_valid", {31'b0, bus_if.instr_valid}, 32'h1);
    end
    bus_if.imem_ack = 1'b0;

    accept(32'h0000_3004);
    check_eq("hs1_addr",      bus_if.imem_addr,          32'h0000_3004);
    check_eq("hs1_req",       {31'b0, bus_if.imem_req},  32'h1);
    check_eq("hs1_cnt",       fetch_cnt,                 32'h1);
    check_eq("hs1_valid",     {31'b0, bus_if.instr_valid}, 32'h0);

    // Jump redirect.
    give_ack(32'h0810_0004);
    accept(32'h0040_0010);
    check_eq("jmp_addr",      bus_if.imem_addr,          32'h0040_0010);
    check_eq("jmp_pc4",       pc_add_4,                  32'h0040_0014);
    check_eq("jmp_cnt",       fetch_cnt,                 32'h2);

    // halt raised during FETCH, coinciding with the ack: still delivered.
    halt = 1'b1;
    next_cycle();
    check_eq("halt_fetch_req", {31'b0, bus_if.imem_req}, 32'h1);
    give_ack(32'hAAAA_0001);
    check_eq("halt_deliver",  bus_if.Instr,              32'hAAAA_0001);
    check_eq("halt_valid",    {31'b0, bus_if.instr_valid}, 32'h1);
    accept(32'h0040_0014);
    check_eq("stop_req",      {31'b0, bus_if.imem_req},  32'h0);
    check_eq("stop_valid",    {31'b0, bus_if.instr_valid}, 32'h0);
    check_eq("stop_state",    32'(dbg_state),            32'(S_STOP));
    check_eq("stop_pc",       pc,                        32'h0040_0014);
    check_eq("stop_cnt",      fetch_cnt,                 32'h3);
    bus_if.imem_ack = 1'b1;
    next_cycle();
    bus_if.imem_ack = 1'b0;
    check_eq("stop_hold",     32'(dbg_state),            32'(S_STOP));
    halt = 1'b0;
    next_cycle();
    check_eq("resume_req",    {31'b0, bus_if.imem_req},  32'h1);
    check_eq("resume_addr",   bus_if.imem_addr,          32'h0040_0014);

    // PC_add_4 wrap at the top of the address space.
    give_ack(32'h0000_0013);
    accept(32'hFFFF_FFFC);
    check_eq("wrap_pc",       pc,                        32'hFFFF_FFFC);
    check_eq("wrap_pc4",      pc_add_4,                  32'h0000_0000);
    check_eq("wrap_cnt",      fetch_cnt,                 32'h4);

    // Misaligned next PC.
    give_ack(32'h0000_0033);
    accept(32'h0000_3006);
`ifdef FETCH_ALIGN_CHECK_EN
    check_eq("mis_pc",        pc,                        32'h0000_3006);
    check_eq("mis_align",     {31'b0, align_err},        32'h1);
    check_eq("mis_req",       {31'b0, bus_if.imem_req},  32'h0);
    repeat (3) next_cycle();
    check_eq("mis_stuck",     32'(dbg_state),            32'(S_STOP));
    check_eq("mis_sticky",    {31'b0, align_err},        32'h1);
`else
    check_eq("mis_pc",        pc,                        32'h0000_3004);
    check_eq("mis_align",     {31'b0, align_err},        32'h0);
    check_eq("mis_req",       {31'b0, bus_if.imem_req},  32'h1);
`endif
    check_eq("mis_cnt",       fetch_cnt,                 32'h5);

    // Reset in the middle of a cycle drops the request at once.
    next_cycle();
    #2;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_req",   {31'b0, bus_if.imem_req},  32'h0);
    check_eq("mid_rst_pc",    pc,                        32'h0000_3000);
    check_eq("mid_rst_cnt",   fetch_cnt,                 32'h0);
    check_eq("mid_rst_align", {31'b0, align_err},        32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
